// File: rtl/hack_uart_loader.sv
// Serial program loader: 8N1 UART receiver feeding big-endian 16-bit
// Hack instruction words into ROM at auto-incrementing addresses.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   rx        UART line, idle high, asynchronous to clk
//   wr_en     one-cycle ROM write strobe
//   wr_addr   word address of the current write (held between strobes)
//   wr_data   instruction word of the current write (held between strobes)
//   busy      high from the first header start bit until done / abort
//   done      one-cycle pulse after the last word of a load is written
//   frame_err sticky bad-stop-bit flag, cleared only by rst
//
// Protocol: 2-byte big-endian word count, then count words, each sent
// high byte first. Each header restarts writing at address 0.

module hack_uart_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_W       = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bst_t;

   typedef enum logic [1:0] {
      L_HDR_HI,
      L_HDR_LO,
      L_W_HI,
      L_W_LO
   } lst_t;

   // rx synchroniser
   logic rx_m_q;
   logic rx_s;

   // bit-level receiver
   bst_t          b_state_q, b_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          start_det;
   logic          glitch;
   logic          byte_valid;
   logic          stop_bad;

   // loader
   lst_t              l_state_q, l_state_d;
   logic [7:0]        cnt_hi_q, cnt_hi_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       rem_q, rem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              last_word;
   logic              hdr_zero;

   // ------------------------------------------------------------
   // State register
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m_q    <= 1'b1;
         rx_s      <= 1'b1;
         b_state_q <= B_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         l_state_q <= L_HDR_HI;
         cnt_hi_q  <= '0;
         hi_q      <= '0;
         rem_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_m_q    <= rx;
         rx_s      <= rx_m_q;
         b_state_q <= b_state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         l_state_q <= l_state_d;
         cnt_hi_q  <= cnt_hi_d;
         hi_q      <= hi_d;
         rem_q     <= rem_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   // ------------------------------------------------------------
   // Bit FSM: next state
   // ------------------------------------------------------------
   always_comb begin
      b_state_d = b_state_q;
      unique case (b_state_q)
         B_IDLE: begin
            if (!rx_s) b_state_d = B_START;
         end
         B_START: begin
            if (cnt_q == HALF)
               b_state_d = rx_s ? B_IDLE : B_DATA;
         end
         B_DATA: begin
            if (cnt_q == LAST && bit_q == 3'd7)
               b_state_d = B_STOP;
         end
         B_STOP: begin
            if (cnt_q == LAST) b_state_d = B_IDLE;
         end
         default: b_state_d = B_IDLE;
      endcase
   end

   // ------------------------------------------------------------
   // Bit FSM: outputs / datapath
   // ------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      sh_d       = sh_q;
      start_det  = 1'b0;
      glitch     = 1'b0;
      byte_valid = 1'b0;
      stop_bad   = 1'b0;
      unique case (b_state_q)
         B_IDLE: begin
            cnt_d     = '0;
            start_det = ~rx_s;
         end
         B_START: begin
            if (cnt_q == HALF) begin
               cnt_d  = '0;
               bit_d  = '0;
               glitch = rx_s;
            end
         end
         B_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               // LSB arrives first, so shift in from the top
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
            end
         end
         B_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d      = '0;
               byte_valid = rx_s;
               stop_bad   = ~rx_s;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign last_word = (rem_q == 16'd1);
   assign hdr_zero  = ({cnt_hi_q, sh_q} == 16'd0);

   // ------------------------------------------------------------
   // Loader FSM: next state
   // ------------------------------------------------------------
   always_comb begin
      l_state_d = l_state_q;
      unique case (l_state_q)
         L_HDR_HI: begin
            if (byte_valid) l_state_d = L_HDR_LO;
         end
         L_HDR_LO: begin
            if (byte_valid)
               l_state_d = hdr_zero ? L_HDR_HI : L_W_HI;
         end
         L_W_HI: begin
            if (byte_valid) l_state_d = L_W_LO;
         end
         L_W_LO: begin
            // stay here through the strobe cycle so the
            // remaining-count check sees the write retire
            if (wr_en_q)
               l_state_d = last_word ? L_HDR_HI : L_W_HI;
         end
         default: l_state_d = L_HDR_HI;
      endcase
      if (stop_bad) l_state_d = L_HDR_HI;
   end

   // ------------------------------------------------------------
   // Loader FSM: outputs / datapath
   // ------------------------------------------------------------
   always_comb begin
      cnt_hi_d = cnt_hi_q;
      hi_d     = hi_q;
      rem_d    = rem_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_en_d  = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ferr_d   = ferr_q | stop_bad;

      // busy tracks the header start bit; a rejected glitch
      // before any header byte drops it again
      if (l_state_q == L_HDR_HI) begin
         if (start_det) busy_d = 1'b1;
         if (glitch)    busy_d = 1'b0;
      end

      if (byte_valid) begin
         unique case (l_state_q)
            L_HDR_HI: begin
               cnt_hi_d = sh_q;
               busy_d   = 1'b1;
            end
            L_HDR_LO: begin
               rem_d  = {cnt_hi_q, sh_q};
               addr_d = '0;
               if (hdr_zero) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
            L_W_HI: begin
               hi_d = sh_q;
            end
            L_W_LO: begin
               wr_en_d = 1'b1;
               data_d  = {hi_q, sh_q};
            end
            default: ;
         endcase
      end

      // retire the write one cycle after the strobe
      if (wr_en_q) begin
         addr_d = addr_q + 1'b1;
         rem_d  = rem_q - 16'd1;
         if (last_word) begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
      end

      if (stop_bad) busy_d = 1'b0;
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = addr_q;
   assign wr_data   = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_hack_uart_loader.sv
// Self-checking bench for hack_uart_loader: directed scenarios plus a
// randomized load compared against a byte-stream reference model.

module tb_hack_uart_loader;

   localparam int CPB    = 4;
   localparam int ADDR_W = 15;

   logic              clk;
   logic              rst;
   logic              rx;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              busy;
   logic              done;
   logic              frame_err;

   int n_checks;
   int n_fail;

   // observed writes / done pulses
   logic [ADDR_W-1:0] mon_addr[$];
   logic [15:0]       mon_data[$];
   int                done_cnt;
   int                done_busy;

   // reference model state
   logic [7:0]        stream[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [15:0]       exp_data[$];

   hack_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .done(done),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
         end
         if (done) begin
            done_cnt++;
            if (busy) done_busy++;
         end
      end
   end

   task automatic clear_mon();
      mon_addr.delete();
      mon_data.delete();
      done_cnt  = 0;
      done_busy = 0;
      stream.delete();
   endtask

   // Loader semantics: word count from the first two bytes (big-endian),
   // then count words from byte pairs, written to addresses 0,1,2,...
   function automatic void build_expected();
      int cnt;
      exp_addr.delete();
      exp_data.delete();
      cnt = (int'(stream[0]) << 8) | int'(stream[1]);
      for (int i = 0; i < cnt; i++) begin
         exp_data.push_back({stream[2 + 2*i], stream[3 + 2*i]});
         exp_addr.push_back(ADDR_W'(i % (1 << ADDR_W)));
      end
   endfunction

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b,
                            input logic stop_v,
                            input int gap);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_v);
      for (int g = 0; g < gap; g++) send_bit(1'b1);
      if (stop_v) stream.push_back(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({wr_en, wr_addr, wr_data, busy, done, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b/%h/%h/%b/%b/%b expected all 0",
                  wr_en, wr_addr, wr_data, busy, done, frame_err);
      end
      rst = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      n_checks++;
      if ({wr_en, busy, done, frame_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b expected 0000",
                  {wr_en, busy, done, frame_err});
      end
   endtask

   task automatic test_two_words();
      clear_mon();
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h02, 1'b1, 1);
      send_byte(8'h12, 1'b1, 1);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL two_busy_mid: got %b expected 1", busy);
      end
      send_byte(8'h34, 1'b1, 1);
      send_byte(8'hFE, 1'b1, 1);
      send_byte(8'hDC, 1'b1, 1);
      repeat (20) @(negedge clk);
      build_expected();
      n_checks++;
      if (mon_data.size() !== 2) begin
         n_fail++;
         $display("FAIL two_nwrites: got %0d expected 2", mon_data.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
               n_fail++;
               $display("FAIL two_write%0d: got %h@%h expected %h@%h", i,
                        mon_data[i], mon_addr[i], exp_data[i], exp_addr[i]);
            end
         end
      end
      n_checks++;
      if (done_cnt !== 1 || done_busy !== 0) begin
         n_fail++;
         $display("FAIL two_done: got %0d pulses (%0d with busy) expected 1 (0)",
                  done_cnt, done_busy);
      end
      n_checks++;
      if (busy !== 1'b0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL two_flags: got busy=%b ferr=%b expected 0 0",
                  busy, frame_err);
      end
   endtask

   task automatic test_zero_len();
      clear_mon();
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_busy_start: got %b expected 1", busy);
      end
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_byte(8'h00, 1'b1, 1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (mon_data.size() !== 0 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL zero_result: got %0d writes %0d done expected 0 1",
                  mon_data.size(), done_cnt);
      end
      n_checks++;
      if (busy !== 1'b0 || wr_addr !== '0) begin
         n_fail++;
         $display("FAIL zero_state: got busy=%b addr=%h expected 0 0000",
                  busy, wr_addr);
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL glitch_idle: got busy=%b done=%0d expected 0 0",
                  busy, done_cnt);
      end
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h01, 1'b1, 1);
      send_byte(8'h80, 1'b1, 1);
      send_byte(8'h00, 1'b1, 1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (mon_data.size() !== 1) begin
         n_fail++;
         $display("FAIL glitch_nwrites: got %0d expected 1", mon_data.size());
      end else begin
         n_checks++;
         if (mon_addr[0] !== '0 || mon_data[0] !== 16'h8000) begin
            n_fail++;
            $display("FAIL glitch_write: got %h@%h expected 8000@0000",
                     mon_data[0], mon_addr[0]);
         end
      end
   endtask

   task automatic test_bad_stop();
      clear_mon();
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h02, 1'b1, 1);
      send_byte(8'hAA, 1'b1, 1);
      send_byte(8'h55, 1'b0, 2);
      repeat (10) @(negedge clk);
      n_checks++;
      if (frame_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL badstop_flags: got ferr=%b busy=%b expected 1 0",
                  frame_err, busy);
      end
      n_checks++;
      if (mon_data.size() !== 0 || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL badstop_quiet: got %0d writes %0d done expected 0 0",
                  mon_data.size(), done_cnt);
      end
      clear_mon();
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h01, 1'b1, 1);
      send_byte(8'h55, 1'b1, 1);
      send_byte(8'h55, 1'b1, 1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (mon_data.size() !== 1 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL badstop_reload: got %0d writes %0d done expected 1 1",
                  mon_data.size(), done_cnt);
      end else begin
         n_checks++;
         if (mon_addr[0] !== '0 || mon_data[0] !== 16'h5555) begin
            n_fail++;
            $display("FAIL badstop_write: got %h@%h expected 5555@0000",
                     mon_data[0], mon_addr[0]);
         end
      end
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL badstop_sticky: got %b expected 1", frame_err);
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h03, 1'b1, 1);
      send_byte(8'h01, 1'b1, 1);
      send_byte(8'h23, 1'b1, 1);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_data.size() !== 1 || wr_data !== 16'h0123) begin
         n_fail++;
         $display("FAIL mid_first_write: got %0d writes data=%h expected 1 0123",
                  mon_data.size(), wr_data);
      end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({wr_en, wr_addr, wr_data, busy, done, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL mid_async_reset: got %b/%h/%h/%b/%b/%b expected all 0",
                  wr_en, wr_addr, wr_data, busy, done, frame_err);
      end
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      clear_mon();
      send_byte(8'h00, 1'b1, 1);
      send_byte(8'h01, 1'b1, 1);
      send_byte(8'h0F, 1'b1, 1);
      send_byte(8'h0F, 1'b1, 1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (mon_data.size() !== 1 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL mid_reload: got %0d writes %0d done expected 1 1",
                  mon_data.size(), done_cnt);
      end else begin
         n_checks++;
         if (mon_addr[0] !== '0 || mon_data[0] !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL mid_write: got %h@%h expected 0F0F@0000",
                     mon_data[0], mon_addr[0]);
         end
      end
   endtask

   task automatic test_random();
      int nw;
      int bad;
      logic [15:0] w;
      nw  = 200;
      bad = 0;
      clear_mon();
      send_byte(8'(nw >> 8), 1'b1, $urandom_range(0, 10));
      send_byte(8'(nw), 1'b1, $urandom_range(0, 10));
      for (int i = 0; i < nw; i++) begin
         w = 16'($urandom);
         send_byte(w[15:8], 1'b1, $urandom_range(0, 10));
         send_byte(w[7:0], 1'b1, $urandom_range(0, 10));
      end
      repeat (20) @(negedge clk);
      build_expected();
      n_checks++;
      if (mon_data.size() !== exp_data.size()) begin
         n_fail++;
         $display("FAIL rand_nwrites: got %0d expected %0d",
                  mon_data.size(), exp_data.size());
      end else begin
         for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
               n_fail++;
               bad++;
               if (bad <= 5)
                  $display("FAIL rand_write%0d: got %h@%h expected %h@%h", i,
                           mon_data[i], mon_addr[i], exp_data[i], exp_addr[i]);
            end
         end
      end
      n_checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rand_done: got %0d pulses busy=%b expected 1 0",
                  done_cnt, busy);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      done_cnt  = 0;
      done_busy = 0;
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      test_reset();
      test_two_words();
      test_zero_len();
      test_glitch();
      test_bad_stop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hack_uart_loader.md
Name: hack_uart_loader

Overview:
- Serial program loader for the Hack CPU on the iCE40 board. It is the receiving end of the host's 8N1 UART transmitter.
- Deserialises bytes, assembles big-endian 16-bit Hack instruction words, and writes them to instruction ROM/RAM at auto-incrementing addresses.
- Sits between the board RX pin and the ROM write port. The CPU is held off while busy is high.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); must be >= 4.
- ADDR_W, 15, width of the write address (Hack ROM is 32K words).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  UART line, idle high, asynchronous to clk.
- wr_en  output  1  one-cycle write strobe to the ROM.
- wr_addr  output  ADDR_W  word address for the current write.
- wr_data  output  16  instruction word for the current write.
- busy  output  1  high from the first header start bit until done.
- done  output  1  one-cycle pulse when the last word has been written.
- frame_err  output  1  sticky flag, set on a bad stop bit.

Behaviour:
- Reset: clock and reset are already decided as one clock `clk` and reset `rst`, asynchronous and active-high. On reset:
  - wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0, frame_err = 0.
  - Both rx synchroniser flops = 1.
  - Bit FSM goes to IDLE; loader FSM goes to HDR_HI.
  - Reset mid-byte or mid-load abandons everything. No partial write is issued.
- rx synchroniser: two flops. All decisions use the second flop (rx_s).
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s = 0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer divide), if rx_s = 1 treat it as a glitch and return to IDLE. Otherwise clear the counter -> DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, LSB first, 8 samples -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s = 1: byte_valid pulses for one cycle -> IDLE.
    - rx_s = 0: set frame_err, no byte_valid -> IDLE.
- Loader FSM states: HDR_HI, HDR_LO, W_HI, W_LO. It advances only on byte_valid.
  - HDR_HI: store count[15:8]; busy <= 1 -> HDR_LO.
  - HDR_LO: store count[7:0]; wr_addr <= 0.
    - Count = 0: pulse done the next cycle, busy <= 0 -> HDR_HI.
    - Otherwise -> W_HI.
  - W_HI: store hi byte -> W_LO.
  - W_LO: the cycle after byte_valid, assert:
    - wr_en = 1
    - wr_data = {hi, lo}
    - wr_addr = the current address
  - After the write:
    - wr_addr increments the cycle after wr_en, wrapping mod 2^ADDR_W.
    - Remaining count decrements.
    - If the count reaches 0: done pulses on the cycle after wr_en, busy <= 0, wr_addr keeps the last written address + 1 -> HDR_HI.
    - Otherwise -> W_HI.
- wr_addr and wr_data hold their values between strobes. The ROM must only sample them when wr_en = 1.
- Frame error: the loader aborts to HDR_HI and busy <= 0. There is no done and no write of the pending half-word. frame_err stays 1 until rst. A new header is still accepted while frame_err = 1.
- Counts larger than 2^ADDR_W words wrap the address. This is not flagged.
- Minimum latency from the low-byte stop-bit sample to wr_en is 1 cycle.

Test Plan:
- Header and two words. CLKS_PER_BIT = 4. Send bytes 00 02 12 34 FE DC.
  - Expect wr_en at addr 0 with data 1234, then at addr 1 with data FEDC.
  - done pulses exactly once after the second write; busy falls with done.
  - frame_err = 0.
- Zero-length load. Send 00 00.
  - Expect busy high from the first start bit, then one done pulse, then busy = 0.
  - No wr_en ever asserted; wr_addr = 0.
- Glitch rejection. Drive rx low for 1 clk (less than CLKS_PER_BIT/2), then high. Then send 00 01 80 00.
  - The glitch produces no byte.
  - One write: addr 0, data 8000.
- Bad stop bit. Send 00 02 AA, then a byte with the stop bit held low.
  - Expect frame_err = 1, busy = 0, no wr_en, no done.
  - Then send 00 01 55 55: one write with data 5555 at addr 0, and frame_err still 1.
- Reset mid-load. Send 00 03 01 23, assert rst during the next byte's data bits, then release.
  - Expect all outputs = 0 immediately (asynchronous).
  - Then send 00 01 0F0F as bytes 0F 0F: write at addr 0 with data 0F0F.
- Random regression. 200 random words, each sent with a random idle gap of 0-10 bits between bytes.
  - Every wr_data/wr_addr pair matches the sent word and its index.
  - Exactly one done pulse.
